alu_arbiter: RTL and testbench

//  Shares one combinational ALU (rs1/rs2/Opcode -> rd, zero, Con_BLT, Con_BGT) between two requesters.

---
 rtl/alu_arbiter_if.sv | 23 ++
 rtl/alu_arbiter.sv | 67 ++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus between two requesters and the shared-ALU arbiter
interface alu_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [2*DATA_WIDTH-1:0]    req_rs1;
  logic [2*DATA_WIDTH-1:0]    req_rs2;
  logic [2*OPCODE_LENGTH-1:0] req_opcode;
  logic [1:0]                 rsp_valid;
  logic [1:0]                 rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_rd;
  logic [2:0]                 rsp_flags;
  modport master (
    output req_valid, req_rs1, req_rs2, req_opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd, rsp_flags
  );
  modport slave (
    input  req_valid, req_rs1, req_rs2, req_opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_rd, rsp_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters, one op in flight
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_arbiter_if.slave             bus,
  output logic [DATA_WIDTH-1:0]    alu_rs1,
  output logic [DATA_WIDTH-1:0]    alu_rs2,
  output logic [OPCODE_LENGTH-1:0] alu_opcode,
  input  logic [DATA_WIDTH-1:0]    alu_rd,
  input  logic                     alu_zero,
  input  logic                     alu_blt,
  input  logic                     alu_bgt,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic   grant;
  logic   last_grant;
  logic   pick;
  // with both ports asking, the one not served last wins
  assign pick          = &bus.req_valid ? ~last_grant : bus.req_valid[1];
  assign bus.req_ready = (state == IDLE && |bus.req_valid) ? (2'b01 << pick) : 2'b00;
  assign busy          = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      bus.rsp_valid <= 2'b00;
      bus.rsp_rd    <= '0;
      bus.rsp_flags <= 3'b000;
      alu_rs1       <= '0;
      alu_rs2       <= '0;
      alu_opcode    <= '0;
      ops_done      <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req_valid) begin
          grant      <= pick;
          alu_rs1    <= pick ? bus.req_rs1[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_rs1[DATA_WIDTH-1:0];
          alu_rs2    <= pick ? bus.req_rs2[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_rs2[DATA_WIDTH-1:0];
          alu_opcode <= pick ? bus.req_opcode[2*OPCODE_LENGTH-1:OPCODE_LENGTH]
                             : bus.req_opcode[OPCODE_LENGTH-1:0];
          state      <= EXEC;
        end
        EXEC: begin
          bus.rsp_rd    <= alu_rd;
          bus.rsp_flags <= {alu_zero, alu_bgt, alu_blt};
          bus.rsp_valid <= 2'b01 << grant;
          state         <= RESP;
        end
        RESP: if (bus.rsp_ready[grant]) begin
          bus.rsp_valid <= 2'b00;
          last_grant    <= grant;
          ops_done      <= ops_done + 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven and sequence checks of alu_arbiter with a response scoreboard
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OL = 5;
  localparam int CW = 4;
  typedef struct {
    int          p;
    logic [31:0] rd;
    logic [2:0]  fl;
  } exp_t;
  typedef struct {
    int          p;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] rd;
    logic [2:0]  fl;
  } vec_t;
  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] alu_rs1, alu_rs2, alu_rd;
  logic [OL-1:0] alu_opcode;
  logic          alu_zero, alu_blt, alu_bgt, busy;
  logic [CW-1:0] ops_done;
  int            tests = 0;
  int            fails = 0;
  exp_t          sb[$];
  exp_t          sb_e;
  logic [31:0]   exp_rd[2];
  logic [2:0]    exp_fl[2];
  vec_t          vt[8];
  alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) bus ();
  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_opcode(alu_opcode),
    .alu_rd(alu_rd), .alu_zero(alu_zero), .alu_blt(alu_blt), .alu_bgt(alu_bgt),
    .busy(busy), .ops_done(ops_done)
  );
  always #5 clk = ~clk;
  // processor ALU stand-in: compare flags only come from SUB
  assign alu_rd   = alu_opcode == 5'd1 ? alu_rs1 + alu_rs2 :
                    alu_opcode == 5'd2 ? alu_rs1 - alu_rs2 :
                    alu_opcode == 5'd3 ? alu_rs1 << alu_rs2[4:0] :
                    alu_opcode == 5'd4 ? {31'b0, alu_rs1 < alu_rs2} : 32'd0;
  assign alu_zero = alu_rd == 32'd0;
  assign alu_blt  = alu_opcode == 5'd2 && $signed(alu_rs1) < $signed(alu_rs2);
  assign alu_bgt  = alu_opcode == 5'd2 && $signed(alu_rs1) > $signed(alu_rs2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      check("req_ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      check("rsp_valid_onehot", 32'(bus.rsp_valid != 2'b11), 1);
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid[p] && bus.req_ready[p]) sb.push_back('{p, exp_rd[p], exp_fl[p]});
        if (bus.rsp_valid[p] && bus.rsp_ready[p]) begin
          if (sb.size() == 0) check("rsp_unexpected_port", 32'(p), 32'hffff_ffff);
          else begin
            sb_e = sb.pop_front();
            check("rsp_port", 32'(p), 32'(sb_e.p));
            check("rsp_rd", bus.rsp_rd, sb_e.rd);
            check("rsp_flags", 32'(bus.rsp_flags), 32'(sb_e.fl));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [31:0] rd, input logic [2:0] fl);
    bus.req_rs1[p*DW +: DW]    = a;
    bus.req_rs2[p*DW +: DW]    = b;
    bus.req_opcode[p*OL +: OL] = op;
    exp_rd[p]                  = rd;
    exp_fl[p]                  = fl;
    bus.req_valid[p]           = 1'b1;
  endtask

  task automatic send(input int p, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] op, input logic [31:0] rd, input logic [2:0] fl);
    logic acc;
    acc = 1'b0;
    set_req(p, a, b, op, rd, fl);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.req_ready[p];
    end
    check("accept_in_time", 32'(acc), 1);
    tick();
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int p);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.rsp_valid[p] && bus.rsp_ready[p];
    end
    check("response_in_time", 32'(got), 1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int od;
    int got;
    logic seen;
    vt[0] = '{1, 32'd3, 32'd3, 5'd2, 32'd0, 3'b100};
    vt[1] = '{0, 32'd5, 32'd7, 5'd2, 32'hffff_fffe, 3'b001};
    vt[2] = '{1, 32'd7, 32'd5, 5'd2, 32'd2, 3'b010};
    vt[3] = '{0, 32'd1, 32'd2, 5'd3, 32'd4, 3'b000};
    vt[4] = '{1, 32'd1, 32'd2, 5'd4, 32'd1, 3'b000};
    vt[5] = '{0, 32'd5, 32'd3, 5'd4, 32'd0, 3'b100};
    vt[6] = '{1, 32'hffff_ffff, 32'd1, 5'd1, 32'd0, 3'b100};
    vt[7] = '{0, 32'd1, 32'd31, 5'd3, 32'h8000_0000, 3'b000};
    bus.req_valid  = 2'b00;
    bus.rsp_ready  = 2'b00;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_opcode = '0;
    exp_rd         = '{32'd0, 32'd0};
    exp_fl         = '{3'd0, 3'd0};
    reset          = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ops_done", 32'(ops_done), 0);
    check("rst_rsp_rd", bus.rsp_rd, 0);
    check("rst_rsp_flags", 32'(bus.rsp_flags), 0);
    check("rst_alu_rs1", alu_rs1, 0);
    check("rst_alu_opcode", 32'(alu_opcode), 0);
    tick();
    reset = 1'b0;
    // single ADD on port 0 with cycle-exact timing
    bus.rsp_ready = 2'b11;
    set_req(0, 32'd1, 32'd2, 5'd1, 32'd3, 3'b000);
    @(negedge clk);
    check("t1_req_ready", 32'(bus.req_ready), 32'b01);
    tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_exec_busy", 32'(busy), 1);
    check("t1_exec_rsp_valid", 32'(bus.rsp_valid), 0);
    check("t1_exec_req_ready", 32'(bus.req_ready), 0);
    check("t1_alu_rs1", alu_rs1, 1);
    check("t1_alu_rs2", alu_rs2, 2);
    check("t1_alu_opcode", 32'(alu_opcode), 1);
    @(negedge clk);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'b01);
    check("t1_rsp_rd", bus.rsp_rd, 3);
    check("t1_rsp_flags", 32'(bus.rsp_flags), 0);
    @(negedge clk);
    check("t1_rsp_cleared", 32'(bus.rsp_valid), 0);
    check("t1_ops_done", 32'(ops_done), 1);
    check("t1_idle", 32'(busy), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      send(vt[i].p, vt[i].a, vt[i].b, vt[i].op, vt[i].rd, vt[i].fl);
      wait_rsp(vt[i].p);
      check("table_ops_done", 32'(ops_done), 32'(i + 2));
    end
    // both ports requesting continuously must alternate, port 0 first
    do_reset();
    set_req(0, 32'd1, 32'd2, 5'd3, 32'd4, 3'b000);
    set_req(1, 32'd1, 32'd2, 5'd4, 32'd1, 3'b000);
    got = 0;
    for (int i = 0; i < 60 && got < 6; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        check("rr_grant", 32'(bus.req_ready), (got % 2) != 0 ? 32'b10 : 32'b01);
        got++;
      end
    end
    check("rr_grant_count", 32'(got), 6);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(1);
    check("rr_ops_done", 32'(ops_done), 6);
    // response backpressure with a competing request pending
    bus.rsp_ready = 2'b00;
    send(0, 32'd10, 32'd20, 5'd1, 32'd30, 3'b000);
    set_req(1, 32'd6, 32'd7, 5'd2, 32'hffff_ffff, 3'b001);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp_valid[0];
    end
    check("bp_rsp_seen", 32'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'b01);
      check("bp_rsp_rd", bus.rsp_rd, 30);
      check("bp_req_ready", 32'(bus.req_ready), 0);
      check("bp_alu_rs1", alu_rs1, 10);
      check("bp_alu_rs2", alu_rs2, 20);
      @(negedge clk);
    end
    od = int'(ops_done);
    tick();
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle", 32'(busy), 0);
    check("bp_release_rsp_valid", 32'(bus.rsp_valid), 0);
    check("bp_ops_done_once", 32'(ops_done), 32'(od + 1));
    check("bp_port1_ready", 32'(bus.req_ready), 32'b10);
    tick();
    bus.req_valid[1] = 1'b0;
    wait_rsp(1);
    check("bp_ops_done_after", 32'(ops_done), 32'(od + 2));
    // reset while an op is executing aborts it
    send(1, 32'd4, 32'd4, 5'd1, 32'd8, 3'b000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rx_busy", 32'(busy), 0);
    check("rx_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rx_alu_rs1", alu_rs1, 0);
    check("rx_alu_rs2", alu_rs2, 0);
    check("rx_alu_opcode", 32'(alu_opcode), 0);
    check("rx_ops_done", 32'(ops_done), 0);
    check("rx_rsp_rd", bus.rsp_rd, 0);
    tick();
    set_req(0, 32'd9, 32'd1, 5'd2, 32'd8, 3'b010);
    set_req(1, 32'd2, 32'd2, 5'd1, 32'd4, 3'b000);
    @(negedge clk);
    check("rx_port0_preferred", 32'(bus.req_ready), 32'b01);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(0);
    // counter wrap
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send(i % 2, 32'(i), 32'd1, 5'd1, 32'(i + 1), 3'b000);
      wait_rsp(i % 2);
    end
    check("wrap_ops_done_max", 32'(ops_done), 15);
    send(1, 32'd0, 32'd0, 5'd1, 32'd0, 3'b100);
    wait_rsp(1);
    check("wrap_ops_done_zero", 32'(ops_done), 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
